add_serial_feeder: RTL and testbench

- Upstream operand sequencer for the 8-bit bit-serial adder.
- Accepts a byte stream over valid/ready and pairs consecutive bytes as operands A then B.
- Launches the adder with a one-cycle enable, holds operands stable, waits a fixed cycle count, then captures the sum.
- Presents the sum on a valid/ready result port with a single-entry output buffer.

---
 rtl/add_serial_feeder_pkg.sv | 20 ++
 rtl/add_serial_feeder_obuf.sv | 47 ++++
 rtl/add_serial_feeder.sv | 101 ++++++++++
 tb/tb_add_serial_feeder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_serial_feeder_pkg.sv
// Shared definitions for the add_serial_feeder operand sequencer.
package add_serial_feeder_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int ADD_CYCLES_DEF = 9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GOT_A   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4
  } state_e;

  // Wait counter must hold ADD_CYCLES-1 without overflow.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/add_serial_feeder_obuf.sv
// Single-entry valid/ready result buffer; a load on the pop edge refills it.
module add_serial_feeder_obuf
  import add_serial_feeder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: load wins over pop so a same-edge capture keeps valid set.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && pop_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/add_serial_feeder.sv
// Pairs incoming bytes into operands, launches the bit-serial adder, waits
// a fixed number of cycles and hands the sum to a one-entry result buffer.
module add_serial_feeder
  import add_serial_feeder_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADD_CYCLES = ADD_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_en,
  input  logic [WIDTH-1:0] add_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam int CW = cnt_width(ADD_CYCLES);

  state_e           state_q;
  logic [WIDTH-1:0] add_a_q, add_b_q;
  logic             add_en_q;
  logic [CW-1:0]    cnt_q;
  logic             xfer_s, cap_s, res_valid_s;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_GOT_A);
  assign xfer_s   = in_valid && in_ready;
  assign cap_s    = (state_q == S_CAPTURE) && (!res_valid_s || res_ready);

  // Sequencer FSM; add_en is set on entry to LAUNCH so it is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      add_a_q  <= '0;
      add_b_q  <= '0;
      add_en_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      add_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (xfer_s) begin
            add_a_q <= in_data;
            state_q <= S_GOT_A;
          end
        end
        S_GOT_A: begin
          if (xfer_s) begin
            add_b_q  <= in_data;
            add_en_q <= 1'b1;
            state_q  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= CW'(ADD_CYCLES - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_CAPTURE: begin
          if (cap_s) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  add_serial_feeder_obuf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (cap_s),
    .data_i  (add_sum),
    .pop_i   (res_ready),
    .valid_o (res_valid_s),
    .data_o  (res_data)
  );

  assign res_valid = res_valid_s;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_en    = add_en_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_add_serial_feeder.sv
// Directed bench for add_serial_feeder with a cycle-accurate adder model.
module tb_add_serial_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default build (ADD_CYCLES = 9)
  logic       in_valid = 1'b0, in_ready, add_en, res_valid, res_ready = 1'b1, busy;
  logic [7:0] in_data = 8'h00, add_a, add_b, add_sum, res_data;
  // ADD_CYCLES = 1 build
  logic       f_in_valid = 1'b0, f_in_ready, f_add_en, f_res_valid, f_res_ready = 1'b1, f_busy;
  logic [7:0] f_in_data = 8'h00, f_add_a, f_add_b, f_add_sum, f_res_data;

  add_serial_feeder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_sum(add_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  add_serial_feeder #(.WIDTH(8), .ADD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
    .add_a(f_add_a), .add_b(f_add_b), .add_en(f_add_en), .add_sum(f_add_sum),
    .res_valid(f_res_valid), .res_ready(f_res_ready), .res_data(f_res_data), .busy(f_busy)
  );

  // Adder model: the sum is wrong until N edges after the add_en cycle.
  logic [7:0] m_cnt = 8'd0, f_m_cnt = 8'd0;
  always @(posedge clk) begin
    if (add_en) m_cnt <= 8'd1;
    else if (m_cnt != 8'd0 && m_cnt != 8'd255) m_cnt <= m_cnt + 8'd1;
    if (f_add_en) f_m_cnt <= 8'd1;
    else if (f_m_cnt != 8'd0 && f_m_cnt != 8'd255) f_m_cnt <= f_m_cnt + 8'd1;
  end
  assign add_sum   = (m_cnt >= 8'd9)   ? (add_a + add_b)     : ~(add_a + add_b);
  assign f_add_sum = (f_m_cnt >= 8'd1) ? (f_add_a + f_add_b) : ~(f_add_a + f_add_b);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one byte until it is accepted; returns at the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100 && !ok; t++) begin
      ok = in_ready;
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_pair(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                          input string name);
    int cyc = 0;
    int en_cnt;
    int unstable = 0;
    logic rdy_cap = 1'b1;
    send_byte(a);
    send_byte(b);
    in_valid = 1'b0;
    en_cnt = add_en ? 1 : 0;
    chk({name, "_launch_in_ready"}, int'(in_ready), 0);
    while (!res_valid && cyc < 60) begin
      if (add_a !== a || add_b !== b) unstable++;
      @(negedge clk);
      cyc++;
      if (add_en) en_cnt++;
      if (cyc == 10) rdy_cap = in_ready;
    end
    chk({name, "_latency"}, cyc, 11);
    chk({name, "_add_en_pulses"}, en_cnt, 1);
    chk({name, "_operands_unstable"}, unstable, 0);
    chk({name, "_capture_in_ready"}, int'(rdy_cap), 0);
    chk({name, "_res_data"}, int'(res_data), int'(exp));
    chk({name, "_idle_in_ready"}, int'(in_ready), 1);
    @(negedge clk);
    chk({name, "_res_valid_drop"}, int'(res_valid), 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[5];

  logic [7:0] sb[6];
  logic [7:0] sexp[3];
  logic [7:0] got[3];
  int         tres[3];

  initial begin
    int cyc, idx, nres, leak, en;
    bit locked, xfer;

    vt[0] = '{a: 8'h12, b: 8'h34, exp: 8'h46};
    vt[1] = '{a: 8'hFF, b: 8'h01, exp: 8'h00};
    vt[2] = '{a: 8'h80, b: 8'h80, exp: 8'h00};
    vt[3] = '{a: 8'h7F, b: 8'h01, exp: 8'h80};
    vt[4] = '{a: 8'hA5, b: 8'h5A, exp: 8'hFF};
    sb    = '{8'h01, 8'h02, 8'h10, 8'h20, 8'hF0, 8'h20};
    sexp  = '{8'h03, 8'h30, 8'h10};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_add_a", int'(add_a), 0);
    chk("rst_add_b", int'(add_b), 0);
    chk("rst_add_en", int'(add_en), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven pairs
    for (int i = 0; i < 5; i++) begin
      run_pair(vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i));
    end

    // Continuous in_valid with six bytes
    idx = 0; nres = 0; leak = 0; locked = 1'b0;
    for (int c = 0; c < 120 && nres < 3; c++) begin
      if (res_valid) begin
        got[nres]  = res_data;
        tres[nres] = c;
        nres++;
        locked = 1'b0;
      end else if (locked && in_ready) begin
        leak++;
      end
      in_valid = (idx < 6);
      in_data  = (idx < 6) ? sb[idx] : 8'h00;
      xfer     = in_valid && in_ready;
      @(negedge clk);
      if (xfer) begin
        idx++;
        if (idx % 2 == 0) locked = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("stream_results", nres, 3);
    chk("stream_bytes", idx, 6);
    chk("stream_in_ready_leak", leak, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("stream_res%0d", i), int'(got[i]), int'(sexp[i]));
    chk("stream_spacing0", tres[1] - tres[0], 13);
    chk("stream_spacing1", tres[2] - tres[1], 13);

    // Back-pressure: second pair stalls in CAPTURE behind the first result
    res_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    in_valid = 1'b0;
    wait_res(cyc);
    chk("bp_latency", cyc, 11);
    send_byte(8'h01);
    send_byte(8'h02);
    in_valid = 1'b0;
    leak = 0;
    for (int c = 0; c < 20; c++) begin
      if (!res_valid || res_data !== 8'h33) leak++;
      @(negedge clk);
    end
    chk("bp_hold", leak, 0);
    chk("bp_res_data", int'(res_data), 8'h33);
    chk("bp_busy_stall", int'(busy), 1);
    chk("bp_in_ready_stall", int'(in_ready), 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_refill_valid", int'(res_valid), 1);
    chk("bp_refill_data", int'(res_data), 8'h03);
    chk("bp_refill_busy", int'(busy), 0);
    @(negedge clk);
    chk("bp_drain_valid", int'(res_valid), 0);

    // Asynchronous reset during WAIT with a buffered result pending
    res_ready = 1'b0;
    send_byte(8'h21);
    send_byte(8'h22);
    in_valid = 1'b0;
    wait_res(cyc);
    chk("mr_buffered", int'(res_valid), 1);
    send_byte(8'h40);
    send_byte(8'h41);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mr_busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_add_a", int'(add_a), 0);
    chk("mr_add_b", int'(add_b), 0);
    chk("mr_add_en", int'(add_en), 0);
    chk("mr_res_valid", int'(res_valid), 0);
    chk("mr_res_data", int'(res_data), 0);
    chk("mr_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    en = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (add_en) en++;
    end
    chk("mr_no_add_en", en, 0);
    run_pair(8'h05, 8'h06, 8'h0B, "mr_pair");

    // ADD_CYCLES = 1 build
    f_in_valid = 1'b1;
    f_in_data  = 8'h01;
    chk("f_in_ready", int'(f_in_ready), 1);
    @(negedge clk);
    f_in_data = 8'h02;
    chk("f_in_ready_b", int'(f_in_ready), 1);
    @(negedge clk);
    f_in_valid = 1'b0;
    chk("f_add_en", int'(f_add_en), 1);
    cyc = 0;
    while (!f_res_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("f_latency", cyc, 3);
    chk("f_res_data", int'(f_res_data), 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
